// File: rtl/pwm_duty_sequencer.sv
// Owns the internal register write bus: forwards SPI writes and autonomously steps
// COMPARE1 through a programmable duty table, one entry per HOLD+1 counter periods.
module pwm_duty_sequencer #(
  parameter int                 ADDR_W   = 6,
  parameter int                 DATA_W   = 8,
  parameter int                 DEPTH    = 8,
  parameter logic [ADDR_W-1:0]  CMP_ADDR = 6'h03
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        spi_addr,
  input  logic [DATA_W-1:0]        spi_wdata,
  input  logic                     spi_we,
  input  logic                     period_wrap,
  output logic [ADDR_W-1:0]        reg_addr,
  output logic [DATA_W-1:0]        reg_wdata,
  output logic                     reg_we,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic [$clog2(DEPTH)-1:0] seq_step
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] TBL_BASE  = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(24);
  localparam logic [ADDR_W-1:0] LEN_ADDR  = ADDR_W'(25);
  localparam logic [ADDR_W-1:0] HOLD_ADDR = ADDR_W'(26);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WRAP,
    ISSUE,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] step_tbl [DEPTH];
  logic              ctrl_en;
  logic              ctrl_loop;
  logic [IDX_W-1:0]  len_last;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] hold_cnt;
  logic              first_wrap;

  logic intercept;
  logic tbl_wr;
  logic ctrl_wr;
  logic pass;
  logic issue_fire;

  assign intercept  = (spi_addr >= TBL_BASE) && (spi_addr <= HOLD_ADDR);
  assign tbl_wr     = spi_we && (spi_addr >= TBL_BASE) && (spi_addr < CTRL_ADDR);
  assign ctrl_wr    = spi_we && (spi_addr == CTRL_ADDR);
  assign pass       = spi_we && !intercept;
  // A pending pass-through wins the bus; any CTRL write cancels an undriven step write.
  assign issue_fire = (state == ISSUE) && !pass && !ctrl_wr;

  // Configuration registers, written directly by intercepted SPI writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the step table is reset because a reset is required to leave every entry at 0;
      // a plain data RAM would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) begin
        step_tbl[i] <= '0;
      end
      ctrl_en   <= 1'b0;
      ctrl_loop <= 1'b0;
      len_last  <= '0;
      hold      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      if (tbl_wr) begin
        step_tbl[spi_addr[IDX_W-1:0]] <= spi_wdata;
      end
      if (spi_we && spi_addr == LEN_ADDR) begin
        len_last <= spi_wdata[IDX_W-1:0];
      end
      if (spi_we && spi_addr == HOLD_ADDR) begin
        hold <= spi_wdata;
      end
      if (ctrl_wr) begin
        ctrl_en   <= spi_wdata[0];
        ctrl_loop <= spi_wdata[1];
      end else if (state == DONE) begin
        ctrl_en <= 1'b0;
      end
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      seq_step   <= '0;
      hold_cnt   <= '0;
      first_wrap <= 1'b0;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (ctrl_wr && spi_wdata[0]) begin
        state      <= WAIT_WRAP;
        seq_step   <= '0;
        hold_cnt   <= '0;
        first_wrap <= 1'b1;
        seq_busy   <= 1'b1;
      end else if (ctrl_wr) begin
        state    <= IDLE;
        seq_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            seq_busy <= 1'b0;
          end
          WAIT_WRAP: begin
            if (period_wrap) begin
              // >= so that a HOLD lowered below the running count still releases the step.
              if (first_wrap || hold_cnt >= hold) begin
                hold_cnt   <= '0;
                first_wrap <= 1'b0;
                state      <= ISSUE;
              end else begin
                hold_cnt <= hold_cnt + DATA_W'(1);
              end
            end
          end
          ISSUE: begin
            if (!pass) begin
              if (seq_step >= len_last) begin
                if (ctrl_loop) begin
                  seq_step <= '0;
                  state    <= WAIT_WRAP;
                end else begin
                  state    <= DONE;
                  seq_busy <= 1'b0;
                  seq_done <= 1'b1;
                end
              end else begin
                seq_step <= seq_step + IDX_W'(1);
                state    <= WAIT_WRAP;
              end
            end
          end
          DONE: begin
            state    <= IDLE;
            seq_busy <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            seq_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered register-bus driver; address and data hold while the strobe is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else if (pass) begin
      reg_we    <= 1'b1;
      reg_addr  <= spi_addr;
      reg_wdata <= spi_wdata;
    end else if (issue_fire) begin
      reg_we    <= 1'b1;
      reg_addr  <= CMP_ADDR;
      reg_wdata <= step_tbl[seq_step];
    end else begin
      reg_we <= 1'b0;
    end
  end

endmodule
